dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 54 +++++
 rtl/dmem_lane_align.sv | 54 +++++
 rtl/dmem_responder.sv | 146 ++++++++++++++
 tb/tb_dmem_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the access-size encodings, the FSM state enum, the latched request
// payload and small lane/alignment helpers used by the top and the lane aligner.
package dmem_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;   // wait-state counter width (0..15)

  // RISC-V funct3[1:0] size encodings; 2'b11 is handled as a word
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Request as latched on acceptance
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [1:0]      size;
    logic            uns;
  } req_t;

  // Lowest byte lane touched by an access: halves snap to an even lane,
  // words always start at lane 0
  function automatic logic [1:0] lane_offset(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
    logic [1:0] off;
    case (size)
      SZ_BYTE: off = addr_lo;
      SZ_HALF: off = {addr_lo[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

  // True when the access does not sit on its natural boundary
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for little-endian sub-word accesses.
// Ports:
//   addr_lo_i   - byte address bits [1:0]
//   size_i      - access size (SZ_BYTE / SZ_HALF / SZ_WORD, 11 = word)
//   unsigned_i  - zero-extend loads when set, sign-extend otherwise
//   wdata_i     - right-aligned store data
//   rword_i     - stored word at the addressed index
//   wr_be_o     - byte enables for a store
//   wr_data_o   - store data shifted onto its lanes
//   rd_data_o   - load data extracted from its lanes and extended
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]      addr_lo_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rword_i,
  output logic [3:0]      wr_be_o,
  output logic [XLEN-1:0] wr_data_o,
  output logic [XLEN-1:0] rd_data_o
);

  logic [1:0]      off_c;
  logic [XLEN-1:0] rshift_c;

  assign off_c = lane_offset(size_i, addr_lo_i);

  // Store side: enables and data shifted up to the first lane
  always_comb begin
    wr_be_o   = 4'b1111;
    wr_data_o = wdata_i << {off_c, 3'b000};
    case (size_i)
      SZ_BYTE: wr_be_o = 4'b0001 << off_c;
      SZ_HALF: wr_be_o = 4'b0011 << off_c;
      default: wr_be_o = 4'b1111;
    endcase
  end

  // Load side: shift the lanes down, then extend
  assign rshift_c = rword_i >> {off_c, 3'b000};

  always_comb begin
    rd_data_o = rshift_c;
    case (size_i)
      SZ_BYTE: rd_data_o = unsigned_i ? {24'h0, rshift_c[7:0]}
                                      : {{24{rshift_c[7]}}, rshift_c[7:0]};
      SZ_HALF: rd_data_o = unsigned_i ? {16'h0, rshift_c[15:0]}
                                      : {{16{rshift_c[15]}}, rshift_c[15:0]};
      default: rd_data_o = rshift_c;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder with a valid/ready request and response.
// A request is latched in IDLE, waits WAIT_CYCLES in BUSY, performs the access
// on the final BUSY edge and presents the response in RESP until taken.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word
// accesses as errors (no memory access) instead of ignoring the low bits.
// Ports:
//   clk_i, rst_i                 - clock, synchronous active-high reset
//   req_valid_i / req_ready_o    - request handshake
//   req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i - request
//   rsp_valid_o / rsp_ready_i    - response handshake
//   rsp_rdata_o, rsp_err_o       - response payload
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q, req_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [XLEN-1:0]  mem_q [DEPTH_WORDS];
  logic [IDX_W-1:0] idx_c;
  logic [XLEN-1:0]  rword_c;
  logic [3:0]       wr_be_c;
  logic [XLEN-1:0]  wr_data_c;
  logic [XLEN-1:0]  ld_data_c;
  logic             misalign_c;
  logic             mem_we_c;
  logic             unused_addr_c;

  // Upper address bits fall outside the array and simply wrap
  assign idx_c         = req_q.addr[IDX_W+1:2];
  assign unused_addr_c = ^req_q.addr[XLEN-1:IDX_W+2];
  assign rword_c       = mem_q[idx_c];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign_c = is_misaligned(req_q.size, req_q.addr[1:0]);
`else
  assign misalign_c = 1'b0;
`endif

  dmem_lane_align u_lane_align (
    .addr_lo_i  (req_q.addr[1:0]),
    .size_i     (req_q.size),
    .unsigned_i (req_q.uns),
    .wdata_i    (req_q.wdata),
    .rword_i    (rword_c),
    .wr_be_o    (wr_be_c),
    .wr_data_o  (wr_data_c),
    .rd_data_o  (ld_data_c)
  );

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  // Next-state, counter, latch and response logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_we_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          req_d.we    = req_we_i;
          req_d.addr  = req_addr_i;
          req_d.wdata = req_wdata_i;
          req_d.size  = req_size_i;
          req_d.uns   = req_unsigned_i;
          cnt_d       = CNT_W'(WAIT_CYCLES);
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_RESP;
          if (misalign_c) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            err_d    = 1'b0;
            rdata_d  = req_q.we ? '0 : ld_data_c;
            mem_we_c = req_q.we;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is never reset; a commit coinciding with reset is dropped
  always_ff @(posedge clk_i) begin
    if (mem_we_c && !rst_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_c[b]) mem_q[idx_c][b*8 +: 8] <= wr_data_c[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH_WORDS=256, WAIT_CYCLES=2).
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned WAIT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = SZ_WORD;
  logic        req_uns = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WAIT)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .req_size_i     (req_size),
    .req_unsigned_i (req_uns),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One full transaction; called at posedge+1 with the DUT idle.
  // Inputs are scrambled while busy so only the latched request may matter.
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] sz, input logic uns,
                      input int hold, output logic [31:0] rd, output logic er);
    int lat;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = sz; req_uns = uns;
    @(posedge clk); #1;
    req_we = ~we; req_addr = addr ^ 32'h4; req_wdata = ~wdata;
    req_size = ~sz; req_uns = ~uns;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    req_valid = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(WAIT + 1));
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_data"}, rsp_rdata, rd);
      chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_idle"}, {30'd0, req_ready, rsp_valid}, 32'b10);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    // Reset
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err",   32'(rsp_err), 32'd0);

    // Word store then load
    xact("st_w10", 1'b1, 32'h10, 32'hDEADBEEF, SZ_WORD, 1'b0, 0, rd, er);
    chk("st_w10_rdata", rd, 32'h0);
    chk("st_w10_err", 32'(er), 32'd0);
    xact("ld_w10", 1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, 0, rd, er);
    chk("ld_w10_rdata", rd, 32'hDEADBEEF);
    chk("ld_w10_err", 32'(er), 32'd0);

    // Byte store over zero and extended byte loads
    xact("clr10", 1'b1, 32'h10, 32'h0, SZ_WORD, 1'b0, 0, rd, er);
    xact("st_b13", 1'b1, 32'h13, 32'h80, SZ_BYTE, 1'b0, 0, rd, er);
    xact("ld_b13s", 1'b0, 32'h13, 32'h0, SZ_BYTE, 1'b0, 0, rd, er);
    chk("ld_b13s_rdata", rd, 32'hFFFFFF80);
    xact("ld_b13u", 1'b0, 32'h13, 32'h0, SZ_BYTE, 1'b1, 0, rd, er);
    chk("ld_b13u_rdata", rd, 32'h00000080);
    xact("ld_w10b", 1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, 0, rd, er);
    chk("ld_w10b_rdata", rd, 32'h80000000);

    // Half and byte lanes on another word
    xact("clr14", 1'b1, 32'h14, 32'h0, SZ_WORD, 1'b0, 0, rd, er);
    xact("st_h16", 1'b1, 32'h16, 32'h1234BEEF, SZ_HALF, 1'b0, 0, rd, er);
    xact("st_b14", 1'b1, 32'h14, 32'h7F, SZ_BYTE, 1'b0, 0, rd, er);
    xact("ld_w14", 1'b0, 32'h14, 32'h0, SZ_WORD, 1'b0, 0, rd, er);
    chk("ld_w14_rdata", rd, 32'hBEEF007F);
    xact("ld_h16s", 1'b0, 32'h16, 32'h0, SZ_HALF, 1'b0, 0, rd, er);
    chk("ld_h16s_rdata", rd, 32'hFFFFBEEF);
    xact("ld_h16u", 1'b0, 32'h16, 32'h0, SZ_HALF, 1'b1, 0, rd, er);
    chk("ld_h16u_rdata", rd, 32'h0000BEEF);
    xact("ld_b14s", 1'b0, 32'h14, 32'h0, SZ_BYTE, 1'b0, 0, rd, er);
    chk("ld_b14s_rdata", rd, 32'h0000007F);

    // Size 11 behaves as a word
    xact("ld_sz3", 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 0, rd, er);
    chk("ld_sz3_rdata", rd, 32'h80000000);

    // Response held for 5 cycles of backpressure
    xact("hold", 1'b0, 32'h14, 32'h0, SZ_WORD, 1'b0, 5, rd, er);
    chk("hold_rdata", rd, 32'hBEEF007F);

    // Reset during BUSY of a store drops it
    xact("st_w20", 1'b1, 32'h20, 32'hCAFEF00D, SZ_WORD, 1'b0, 0, rd, er);
    xact("ld_pre", 1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, 0, rd, er);
    chk("ld_pre_rdata", rsp_rdata, 32'h80000000);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_size = SZ_WORD; req_uns = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("busy_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstb_ready", 32'(req_ready), 32'd1);
    chk("rstb_valid", 32'(rsp_valid), 32'd0);
    chk("rstb_rdata", rsp_rdata, 32'd0);
    chk("rstb_err",   32'(rsp_err), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    xact("ld_w20", 1'b0, 32'h20, 32'h0, SZ_WORD, 1'b0, 0, rd, er);
    chk("ld_w20_rdata", rd, 32'hCAFEF00D);

    // Reset during RESP discards the response
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_size = SZ_WORD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (WAIT + 1) @(posedge clk);
    #1;
    chk("resp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_rdata", rsp_rdata, 32'hCAFEF00D);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstr_valid", 32'(rsp_valid), 32'd0);
    chk("rstr_rdata", rsp_rdata, 32'd0);

    // Address wrap
    xact("st_w400", 1'b1, 32'h400, 32'hA5A5A5A5, SZ_WORD, 1'b0, 0, rd, er);
    xact("ld_w000", 1'b0, 32'h000, 32'h0, SZ_WORD, 1'b0, 0, rd, er);
    chk("ld_w000_rdata", rd, 32'hA5A5A5A5);

    // Misaligned accesses
`ifdef DMEM_MISALIGN_TRAP_EN
    xact("ld_w02", 1'b0, 32'h02, 32'h0, SZ_WORD, 1'b0, 0, rd, er);
    chk("ld_w02_rdata", rd, 32'h0);
    chk("ld_w02_err", 32'(er), 32'd1);
    xact("st_w01", 1'b1, 32'h01, 32'h11111111, SZ_WORD, 1'b0, 0, rd, er);
    chk("st_w01_err", 32'(er), 32'd1);
    xact("ld_h03", 1'b0, 32'h03, 32'h0, SZ_HALF, 1'b1, 0, rd, er);
    chk("ld_h03_err", 32'(er), 32'd1);
    xact("ld_w00c", 1'b0, 32'h00, 32'h0, SZ_WORD, 1'b0, 0, rd, er);
    chk("ld_w00c_rdata", rd, 32'hA5A5A5A5);
    chk("ld_w00c_err", 32'(er), 32'd0);
`else
    xact("ld_w02", 1'b0, 32'h02, 32'h0, SZ_WORD, 1'b0, 0, rd, er);
    chk("ld_w02_rdata", rd, 32'hA5A5A5A5);
    chk("ld_w02_err", 32'(er), 32'd0);
    xact("ld_h03u", 1'b0, 32'h03, 32'h0, SZ_HALF, 1'b1, 0, rd, er);
    chk("ld_h03u_rdata", rd, 32'h0000A5A5);
    xact("ld_h03s", 1'b0, 32'h03, 32'h0, SZ_HALF, 1'b0, 0, rd, er);
    chk("ld_h03s_rdata", rd, 32'hFFFFA5A5);
    chk("ld_h03s_err", 32'(er), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
